// File: rtl/image_paste_if.sv
// Pixel-path bundle for image_paste: upstream FIFO read side plus the raster video output.
// master = the raster generator, slave = its environment (FIFO + encoder).
interface image_paste_if;
  logic        fifo_empty;
  logic [23:0] fifo_data;
  logic        fifo_rd;
  logic        hs_o;
  logic        vs_o;
  logic        de_o;
  logic [23:0] rgb_o;
  logic        frame_start;
  logic        underflow;

  modport master (
    input  fifo_empty, fifo_data,
    output fifo_rd, hs_o, vs_o, de_o, rgb_o, frame_start, underflow
  );

  modport slave (
    output fifo_empty, fifo_data,
    input  fifo_rd, hs_o, vs_o, de_o, rgb_o, frame_start, underflow
  );
endinterface

// File: rtl/image_paste.sv
// Full-frame raster generator that pastes a windowed sub-image (read from a FIFO) into a border-coloured frame.
// Optional IMAGE_PASTE_UFCNT_EN adds a saturating cross-frame underflow event counter (underflow_cnt).
module image_paste #(
  parameter logic [11:0] H_DISP      = 12'd1280,
  parameter logic [11:0] V_DISP      = 12'd720,
  parameter logic [11:0] H_FP        = 12'd110,
  parameter logic [11:0] H_SYNC      = 12'd40,
  parameter logic [11:0] H_BP        = 12'd220,
  parameter logic [11:0] V_FP        = 12'd5,
  parameter logic [11:0] V_SYNC      = 12'd5,
  parameter logic [11:0] V_BP        = 12'd20,
  parameter int unsigned X_RES_WIDTH = 11,
  parameter int unsigned Y_RES_WIDTH = 11,
  parameter logic [23:0] BORDER_RGB  = 24'h000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [X_RES_WIDTH-1:0] start_x,
  input  logic [Y_RES_WIDTH-1:0] start_y,
  input  logic [X_RES_WIDTH-1:0] end_x,
  input  logic [Y_RES_WIDTH-1:0] end_y,
  image_paste_if.master          bus
`ifdef IMAGE_PASTE_UFCNT_EN
  ,
  output logic [15:0]            underflow_cnt
`endif
);

  localparam int unsigned CNT_W = 12;
  localparam int unsigned XY_W  = (X_RES_WIDTH > Y_RES_WIDTH) ? X_RES_WIDTH : Y_RES_WIDTH;
  localparam int unsigned CMP_W = (XY_W > CNT_W) ? XY_W : CNT_W;

  localparam logic [CNT_W-1:0] H_LAST     = H_DISP + H_FP + H_SYNC + H_BP - 12'd1;
  localparam logic [CNT_W-1:0] V_LAST     = V_DISP + V_FP + V_SYNC + V_BP - 12'd1;
  localparam logic [CNT_W-1:0] H_SYNC_BEG = H_DISP + H_FP;
  localparam logic [CNT_W-1:0] H_SYNC_END = H_DISP + H_FP + H_SYNC;
  localparam logic [CNT_W-1:0] V_SYNC_BEG = V_DISP + V_FP;
  localparam logic [CNT_W-1:0] V_SYNC_END = V_DISP + V_FP + V_SYNC;

  logic [CNT_W-1:0]       h_cnt, v_cnt;
  logic [X_RES_WIDTH-1:0] win_sx_q, win_ex_q, win_sx, win_ex;
  logic [Y_RES_WIDTH-1:0] win_sy_q, win_ey_q, win_sy, win_ey;
  logic                   origin, active, hsync, vsync, in_win, uf_ev, rd, rd_q;

  // Stage 0: decode counters; the origin pixel already uses the freshly sampled window.
  always_comb begin
    origin = (h_cnt == '0) && (v_cnt == '0);
    win_sx = origin ? start_x : win_sx_q;
    win_ex = origin ? end_x   : win_ex_q;
    win_sy = origin ? start_y : win_sy_q;
    win_ey = origin ? end_y   : win_ey_q;
    active = (h_cnt < H_DISP) && (v_cnt < V_DISP);
    hsync  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    vsync  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    in_win = active
           && (CMP_W'(h_cnt) >= CMP_W'(win_sx)) && (CMP_W'(h_cnt) < CMP_W'(win_ex))
           && (CMP_W'(v_cnt) >= CMP_W'(win_sy)) && (CMP_W'(v_cnt) < CMP_W'(win_ey));
    uf_ev  = in_win && bus.fifo_empty;
    // Reset gating keeps the strobe low even when the origin pixel lies inside the window.
    rd     = in_win && !bus.fifo_empty && rst_n;
  end

  assign bus.fifo_rd = rd;

  // Raster counters and per-frame window latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      win_sx_q <= '0;
      win_ex_q <= '0;
      win_sy_q <= '0;
      win_ey_q <= '0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
      if (origin) begin
        win_sx_q <= start_x;
        win_ex_q <= end_x;
        win_sy_q <= start_y;
        win_ey_q <= end_y;
      end
    end
  end

  // Stage 1: timing outputs, read tag and underflow flag (frame clear first, then new event).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.hs_o        <= 1'b0;
      bus.vs_o        <= 1'b0;
      bus.de_o        <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.underflow   <= 1'b0;
      rd_q            <= 1'b0;
    end else begin
      bus.hs_o        <= hsync;
      bus.vs_o        <= vsync;
      bus.de_o        <= active;
      bus.frame_start <= origin;
      bus.underflow   <= uf_ev | (bus.underflow & ~origin);
      rd_q            <= rd;
    end
  end

  // FIFO word lands one cycle after its strobe, aligned with the stage-1 timing.
  assign bus.rgb_o = rd_q ? bus.fifo_data : (bus.de_o ? BORDER_RGB : 24'h000000);

`ifdef IMAGE_PASTE_UFCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_cnt <= 16'h0000;
    end else if (uf_ev && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/image_paste.md
Name: image_paste

Overview:
- Full-frame video raster generator that places a cropped sub-image back into a full display frame.
- Reads sub-image pixels from an upstream FIFO (show-ahead read, 1-cycle data latency) only while the raster is inside the configured window; outside the window it drives a border colour.
- Sits downstream of the crop/scale path and upstream of the HDMI/LCD output encoder.

Parameters:
- H_DISP, 12'd1280, active pixels per line
- V_DISP, 12'd720, active lines per frame
- H_FP, 12'd110, horizontal front porch
- H_SYNC, 12'd40, hsync width
- H_BP, 12'd220, horizontal back porch
- V_FP, 12'd5, vertical front porch (lines)
- V_SYNC, 12'd5, vsync width (lines)
- V_BP, 12'd20, vertical back porch (lines)
- X_RES_WIDTH, 11, width of window x controls
- Y_RES_WIDTH, 11, width of window y controls
- BORDER_RGB, 24'h000000, colour outside the window or on underflow

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- start_x  in  X_RES_WIDTH  window left edge, inclusive
- start_y  in  Y_RES_WIDTH  window top edge, inclusive
- end_x  in  X_RES_WIDTH  window right edge, exclusive
- end_y  in  Y_RES_WIDTH  window bottom edge, exclusive
- fifo_empty  in  1  upstream FIFO empty
- fifo_data  in  24  upstream FIFO read data, valid the cycle after fifo_rd
- fifo_rd  out  1  FIFO read strobe (combinational from registered state)
- hs_o  out  1  hsync, active high
- vs_o  out  1  vsync, active high
- de_o  out  1  active video
- rgb_o  out  24  pixel data
- frame_start  out  1  one-cycle pulse at h_cnt==0 && v_cnt==0
- underflow  out  1  sticky; set when a window pixel finds fifo_empty, cleared at frame_start

Behaviour:
- Reset: clk domain only. rst_n=0 clears h_cnt, v_cnt, the window latch, and all output registers immediately (asynchronous). While in reset, hs_o=vs_o=de_o=0, rgb_o=0, fifo_rd=0, frame_start=0, underflow=0.
- Counters:
  - H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP; h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - At the h wrap, v_cnt increments. V_TOTAL is defined likewise; v_cnt wraps to 0.
  - Active region: h_cnt<H_DISP && v_cnt<V_DISP.
  - hsync region: H_DISP+H_FP <= h_cnt < H_DISP+H_FP+H_SYNC. vsync uses the same form on v_cnt.
- Window latch: start/end values are sampled into internal registers when h_cnt==0 && v_cnt==0. Changes mid-frame take effect at the next frame.
- Stage 0 (combinational on counters):
  - in_win = active && start_x<=h_cnt<end_x && start_y<=v_cnt<end_y.
  - Comparisons are unsigned, with counters zero-extended.
  - fifo_rd = in_win && !fifo_empty.
- Stage 1 (registered, 1-cycle latency from counters):
  - hs_o, vs_o, de_o are delayed copies of stage-0 hsync, vsync, and active.
  - rgb_o = fifo_data if the registered fifo_rd was 1; else BORDER_RGB if de_o=1; else 24'h0.
- Underflow handling:
  - An in_win pixel with fifo_empty=1 issues no read, outputs BORDER_RGB, and sets underflow.
  - Subsequent pixels are not realigned; the skipped data shifts one pixel later.
- Degenerate window: start_x>=end_x or start_y>=end_y → no reads for the whole frame; all active pixels are BORDER_RGB.
- Window clipping: end_x>H_DISP or end_y>V_DISP is clipped to the active area by the active term.
- frame_start: registered, aligned with stage 1. When frame_start and an underflow event coincide, underflow ends set: clear has priority for the old frame, then the new event sets it.

Optional Feature:
- Macro: IMAGE_PASTE_UFCNT_EN.
- Defined:
  - Adds output port underflow_cnt [15:0]. It counts underflow events across frames, saturating at 16'hFFFF.
  - It is cleared only by rst_n.
- Undefined: the port and counter are absent; only the sticky underflow flag exists.

Test Plan:
- Use H_DISP=8, V_DISP=4, H_FP=H_SYNC=H_BP=2, V_FP=V_SYNC=V_BP=1 for all cases.
- Reset/timing: release rst_n → frame_start 1 cycle after h_cnt=0,v_cnt=0; hs_o high for 2 cycles per 14-cycle line; vs_o high for exactly 14 cycles per 98-cycle frame; de_o high 8 cycles on each of lines 0-3.
- Window fill: window (2,1)-(6,3), FIFO preloaded with 8 words 0x000001..0x000008 → exactly 8 fifo_rd pulses. Line 1 x=2..5 outputs 1..4, line 2 outputs 5..8, all other active pixels are BORDER_RGB, underflow=0.
- Underflow: same window, FIFO holds 3 words → 3 reads, the remaining 5 window pixels output BORDER_RGB. underflow rises on the 4th window pixel and clears at the next frame_start. With IMAGE_PASTE_UFCNT_EN, underflow_cnt=5.
- Degenerate window: start_x=5,end_x=5 with a full FIFO → zero fifo_rd pulses for a frame; all 32 active pixels are BORDER_RGB.
- Mid-frame change: change the window to (0,0)-(8,4) during line 2 → current frame keeps the old window; the next frame issues 32 reads.
- Async reset mid-line: assert rst_n low during an active window pixel → all outputs are 0 in the same cycle without a clock edge. After release, the counters restart at 0 and no FIFO read is lost or duplicated at release.
